// File: rtl/bist_scan_ctrl.sv
// bist_scan_ctrl: test-per-scan BIST sequencer for one CUT scan chain.
// Resets the CUT, then runs NUM_PATTERNS load/capture iterations fed by a
// 16-bit LFSR, compacts every chain bit and primary-output word into a
// 16-bit MISR, unloads the last response and compares against GOLDEN.
module bist_scan_ctrl #(
   parameter int          CHAIN_LEN    = 12,
   parameter int          NUM_PATTERNS = 100,
   parameter int          PI_W         = 5,
   parameter int          PO_W         = 9,
   parameter logic [15:0] LFSR_SEED    = 16'hACE1,
   parameter logic [15:0] MISR_SEED    = 16'h0000,
   parameter logic [15:0] GOLDEN       = 16'h0000
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            start,
   output logic            busy,
   output logic            done,
   output logic            pass,
   output logic [15:0]     signature,
   output logic            cut_reset,
   output logic            cut_scan_en,
   output logic            cut_scan_in,
   input  logic            cut_scan_out,
   output logic [PI_W-1:0] cut_pi,
   input  logic [PO_W-1:0] cut_po
);

   localparam int BW = $clog2(CHAIN_LEN + 1);
   localparam int PW = $clog2(NUM_PATTERNS + 1);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_INIT    = 3'd1,
      ST_SHIFT   = 3'd2,
      ST_CAPTURE = 3'd3,
      ST_UNLOAD  = 3'd4,
      ST_DONE    = 3'd5
   } state_t;

   state_t          state_r;
   state_t          state_s;
   logic [15:0]     lfsr_r;
   logic [15:0]     misr_r;
   logic [BW-1:0]   bit_cnt_r;
   logic [PW-1:0]   pat_cnt_r;
   logic            pass_r;

   logic            bit_last_s;
   logic [PW-1:0]   pat_inc_s;
   logic [15:0]     misr_d_s;
   logic [15:0]     misr_next_s;

   // Pattern generator: taps 0,2,3,5, shifting toward bit 0.
   function automatic logic [15:0] lfsr_step(input logic [15:0] l);
      logic fb;
      fb = l[0] ^ l[2] ^ l[3] ^ l[5];
      return {fb, l[15:1]};
   endfunction

   // Response compactor: taps 15,13,12,10 shifting upward, data XORed in.
   function automatic logic [15:0] misr_step(input logic [15:0] m, input logic [15:0] d);
      logic fb;
      fb = m[15] ^ m[13] ^ m[12] ^ m[10];
      return {m[14:0], fb} ^ d;
   endfunction

   // Counter terminal conditions and MISR input selection.
   always_comb begin
      bit_last_s = (bit_cnt_r == BW'(CHAIN_LEN - 1));
      if (pat_cnt_r == PW'(NUM_PATTERNS)) begin
         pat_inc_s = pat_cnt_r;
      end else begin
         pat_inc_s = pat_cnt_r + PW'(1);
      end
      if (state_r == ST_CAPTURE) begin
         misr_d_s = 16'(cut_po);
      end else begin
         misr_d_s = {15'b0, cut_scan_out};
      end
      misr_next_s = misr_step(misr_r, misr_d_s);
   end

   // Next-state logic for the session sequencer.
   always_comb begin
      state_s = state_r;
      case (state_r)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_s = ST_INIT;
            end else begin
               state_s = state_r;
            end
         end
         ST_INIT: state_s = ST_SHIFT;
         ST_SHIFT: begin
            if (bit_last_s) begin
               state_s = ST_CAPTURE;
            end else begin
               state_s = ST_SHIFT;
            end
         end
         ST_CAPTURE: begin
            if (pat_inc_s < PW'(NUM_PATTERNS)) begin
               state_s = ST_SHIFT;
            end else begin
               state_s = ST_UNLOAD;
            end
         end
         ST_UNLOAD: begin
            if (bit_last_s) begin
               state_s = ST_DONE;
            end else begin
               state_s = ST_UNLOAD;
            end
         end
         default: state_s = ST_IDLE;
      endcase
   end

   // State register; reset aborts any session immediately.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // LFSR, MISR, counters and the pass flag, advanced per current state.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         lfsr_r    <= LFSR_SEED;
         misr_r    <= MISR_SEED;
         bit_cnt_r <= {BW{1'b0}};
         pat_cnt_r <= {PW{1'b0}};
         pass_r    <= 1'b0;
      end else begin
         case (state_r)
            ST_INIT: begin
               lfsr_r    <= LFSR_SEED;
               misr_r    <= MISR_SEED;
               bit_cnt_r <= {BW{1'b0}};
               pat_cnt_r <= {PW{1'b0}};
               pass_r    <= 1'b0;
            end
            ST_SHIFT: begin
               lfsr_r    <= lfsr_step(lfsr_r);
               misr_r    <= misr_next_s;
               bit_cnt_r <= bit_last_s ? {BW{1'b0}} : bit_cnt_r + BW'(1);
            end
            ST_CAPTURE: begin
               lfsr_r    <= lfsr_step(lfsr_r);
               misr_r    <= misr_next_s;
               pat_cnt_r <= pat_inc_s;
            end
            ST_UNLOAD: begin
               misr_r    <= misr_next_s;
               bit_cnt_r <= bit_last_s ? {BW{1'b0}} : bit_cnt_r + BW'(1);
               // The verdict uses the signature that becomes visible in DONE.
               if (bit_last_s) begin
                  pass_r <= (misr_next_s == GOLDEN);
               end else begin
                  pass_r <= pass_r;
               end
            end
            default: begin
               lfsr_r <= lfsr_r;
               misr_r <= misr_r;
            end
         endcase
      end
   end

   // Status and CUT drive decode from the registered state.
   always_comb begin
      busy        = 1'b0;
      done        = 1'b0;
      cut_reset   = 1'b0;
      cut_scan_en = 1'b0;
      cut_scan_in = 1'b0;
      cut_pi      = {PI_W{1'b0}};
      case (state_r)
         ST_INIT: begin
            busy      = 1'b1;
            cut_reset = 1'b1;
         end
         ST_SHIFT: begin
            busy        = 1'b1;
            cut_scan_en = 1'b1;
            cut_scan_in = lfsr_r[0];
         end
         ST_CAPTURE: begin
            busy   = 1'b1;
            cut_pi = lfsr_r[PI_W-1:0];
         end
         ST_UNLOAD: begin
            busy        = 1'b1;
            cut_scan_en = 1'b1;
         end
         ST_DONE: done = 1'b1;
         default: busy = 1'b0;
      endcase
   end

   assign pass      = pass_r;
   assign signature = misr_r;

endmodule

// File: tb/tb_bist_scan_ctrl.sv
// Bench for bist_scan_ctrl with a 4-flop shift-register CUT stub.
// Expected control timing comes from the session arithmetic; the expected
// signature comes from a pattern-level model of the stub under test.
module tb_bist_scan_ctrl;

   localparam int          CL    = 4;
   localparam int          NP    = 2;
   localparam int          PIW   = 5;
   localparam int          POW   = 9;
   localparam logic [15:0] LS    = 16'hACE1;
   localparam logic [15:0] MS    = 16'h5A3C;
   localparam int          TOTAL = 1 + NP * (CL + 1) + CL;

   function automatic logic [15:0] lfsr_next(input logic [15:0] l);
      return {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
   endfunction

   function automatic logic [15:0] misr_next(input logic [15:0] m, input logic [15:0] d);
      return {m[14:0], m[15] ^ m[13] ^ m[12] ^ m[10]} ^ d;
   endfunction

   // Whole-session reference: load vectors, captures, unload, on the stub.
   function automatic logic [15:0] model_sig(input int flip_pat, input int flip_bit);
      logic [15:0] lf;
      logic [15:0] ms;
      logic [3:0]  ch;
      logic [4:0]  pi;
      logic [8:0]  po;
      logic [8:0]  one;
      lf  = LS;
      ms  = MS;
      ch  = 4'b0;
      one = 9'd1;
      for (int p = 0; p < NP; p++) begin
         for (int i = 0; i < CL; i++) begin
            ms = misr_next(ms, {15'b0, ch[3]});
            ch = {ch[2:0], lf[0]};
            lf = lfsr_next(lf);
         end
         pi = lf[4:0];
         po = {ch, pi};
         if (p == flip_pat) po = po ^ (one << flip_bit);
         ms = misr_next(ms, {7'b0, po});
         ch = ch ^ pi[3:0] ^ {ch[2:0], pi[4]};
         lf = lfsr_next(lf);
      end
      for (int i = 0; i < CL; i++) begin
         ms = misr_next(ms, {15'b0, ch[3]});
         ch = {ch[2:0], 1'b0};
      end
      return ms;
   endfunction

   localparam logic [15:0] GOLD = model_sig(-1, 0);

   logic            clock = 1'b0;
   logic            reset;
   logic            start;
   logic            busy, done, pass;
   logic [15:0]     signature;
   logic            cut_reset, cut_scan_en, cut_scan_in, cut_scan_out;
   logic [PIW-1:0]  cut_pi;
   logic [POW-1:0]  cut_po;
   logic [3:0]      chain;
   logic [POW-1:0]  po_flip;
   int              checks = 0;
   int              errors = 0;

   always #5 clock = ~clock;

   bist_scan_ctrl #(
      .CHAIN_LEN(CL), .NUM_PATTERNS(NP), .PI_W(PIW), .PO_W(POW),
      .LFSR_SEED(LS), .MISR_SEED(MS), .GOLDEN(GOLD)
   ) dut (
      .clock(clock), .reset(reset), .start(start), .busy(busy), .done(done),
      .pass(pass), .signature(signature), .cut_reset(cut_reset),
      .cut_scan_en(cut_scan_en), .cut_scan_in(cut_scan_in),
      .cut_scan_out(cut_scan_out), .cut_pi(cut_pi), .cut_po(cut_po)
   );

   // CUT stub: scan shift register with a small functional capture update.
   always_ff @(posedge clock) begin
      if (cut_reset) chain <= 4'b0;
      else if (cut_scan_en) chain <= {chain[2:0], cut_scan_in};
      else chain <= chain ^ cut_pi[3:0] ^ {chain[2:0], cut_pi[4]};
   end
   assign cut_scan_out = chain[3];
   assign cut_po       = {chain, cut_pi} ^ po_flip;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // 0 INIT, 1 SHIFT, 2 CAPTURE, 3 UNLOAD, 4 DONE for the cycle after edge n.
   function automatic int phase_of(input int n);
      int t;
      if (n == 0) return 0;
      t = n - 1;
      if (t < NP * (CL + 1)) return ((t % (CL + 1)) < CL) ? 1 : 2;
      if (t < NP * (CL + 1) + CL) return 3;
      return 4;
   endfunction

   task automatic run_session(input int flip_pat, input int flip_bit, input int start_at,
                              output logic [15:0] sig, output logic ps);
      logic [15:0] m_lfsr;
      logic [3:0]  bits;
      logic [9:0]  exp_ctl;
      logic [15:0] exp_sig;
      int          ph;
      m_lfsr = LS;
      bits   = 4'b0;
      start  = 1'b1;
      for (int n = 0; n <= TOTAL; n++) begin
         @(posedge clock);
         #1;
         ph = phase_of(n);
         if (ph == 0) m_lfsr = LS;
         exp_ctl = {ph < 4, ph == 4, ph == 0, (ph == 1) || (ph == 3),
                    (ph == 1) ? m_lfsr[0] : 1'b0,
                    (ph == 2) ? m_lfsr[4:0] : 5'b0};
         chk($sformatf("ctl_edge%0d", n), 32'({busy, done, cut_reset, cut_scan_en, cut_scan_in, cut_pi}),
             32'(exp_ctl));
         if (ph == 1 && n <= CL) bits = {bits[2:0], cut_scan_in};
         if (n == CL + 1) chk("lfsr_first4", 32'(bits), 32'(4'b1000));
         if (ph == 2 && ((n - 1) / (CL + 1)) == flip_pat) po_flip = POW'(1) << flip_bit;
         else po_flip = '0;
         if (ph == 1 || ph == 2) m_lfsr = lfsr_next(m_lfsr);
         start = (n == start_at) ? 1'b1 : 1'b0;
      end
      exp_sig = model_sig(flip_pat, flip_bit);
      chk("final_sig", 32'(signature), 32'(exp_sig));
      chk("final_pass", 32'(pass), 32'(exp_sig == GOLD));
      sig = signature;
      ps  = pass;
   endtask

   initial begin
      logic [15:0] sig1, sig;
      logic        ps;
      int          fb, p, target;
      reset   = 1'b0;
      start   = 1'b0;
      po_flip = '0;
      // Reset held low with random start: outputs must stay at reset values.
      for (int i = 0; i < 4; i++) begin
         start = 1'($urandom_range(0, 1));
         @(posedge clock);
         #1;
         chk("rst_outs", 32'({busy, done, pass, cut_reset, cut_scan_en, cut_scan_in, cut_pi}), 32'd0);
         chk("rst_sig", 32'(signature), 32'(MS));
      end
      start = 1'b0;
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      chk("idle_no_start", 32'({busy, done}), 32'd0);

      // Clean session: pass expected against the model-derived golden value.
      run_session(-1, 0, -1, sig1, ps);
      chk("s1_pass", 32'(ps), 32'd1);
      chk("s1_sig_golden", 32'(sig1), 32'(GOLD));
      for (int i = 0; i < 3; i++) begin
         @(posedge clock);
         #1;
         chk("done_sticky", 32'({done, pass, signature}), 32'({1'b1, 1'b1, sig1}));
      end

      // Restart from DONE with a stray start pulse inside the first SHIFT.
      run_session(-1, 0, 1 + $urandom_range(0, CL - 1), sig, ps);
      chk("s2_repeat_sig", 32'(sig), 32'(sig1));

      // One inverted primary-output bit during the second capture.
      fb = $urandom_range(0, POW - 1);
      run_session(1, fb, -1, sig, ps);
      chk("s3_fail_pass", 32'(ps), 32'd0);
      chk("s3_sig_ne_golden", 32'(sig != GOLD), 32'd1);

      // Abort with reset between edges during a random CAPTURE.
      p      = $urandom_range(0, NP - 1);
      target = 1 + p * (CL + 1) + CL;
      start  = 1'b1;
      @(posedge clock);
      #1;
      start = 1'b0;
      repeat (target) @(posedge clock);
      #1;
      chk("pre_abort_capture", 32'({busy, cut_scan_en, cut_reset}), 32'(3'b100));
      #2;
      reset = 1'b0;
      #1;
      chk("abort_outs", 32'({busy, done, pass, cut_reset, cut_scan_en, cut_scan_in, cut_pi}), 32'd0);
      chk("abort_sig", 32'(signature), 32'(MS));
      for (int i = 0; i < 3; i++) begin
         start = 1'($urandom_range(0, 1));
         @(posedge clock);
         #1;
         chk("abort_hold", 32'({busy, done, signature}), 32'({2'b00, MS}));
      end
      start = 1'b0;
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);

      run_session(-1, 0, -1, sig, ps);
      chk("s4_after_abort_sig", 32'(sig), 32'(sig1));
      chk("s4_after_abort_pass", 32'(ps), 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/bist_scan_ctrl.md
# bist_scan_ctrl

Test-per-scan BIST controller that sequences a single scan chain of the circuit under test (CUT). On `start` it resets the CUT, then repeats load/capture cycles. Each load shifts LFSR pseudo-random bits into the chain while the previous response shifts out. Each capture drives LFSR bits onto the CUT primary inputs and pulses functional mode. All chain and primary-output responses are compacted in a MISR, and the final signature is compared with a golden value. It sits between the top-level test access logic and the CUT's `scan_in`/`scan_out`/`scan_en` pins.

## Interface
Parameters:
- `CHAIN_LEN`, 12: scan flops in the CUT chain (≥2).
- `NUM_PATTERNS`, 100: load/capture iterations per session (≥1).
- `PI_W`, 5: CUT primary-input width driven during capture (≤16).
- `PO_W`, 9: CUT primary-output width compacted at capture (≤16).
- `LFSR_SEED`, 16'hACE1: LFSR value loaded in INIT (non-zero).
- `MISR_SEED`, 16'h0000: MISR value loaded in INIT.
- `GOLDEN`, 16'h0000: expected final signature.

Ports:
- `clock` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low. All state clears immediately.
- `start` in 1: session request, sampled in IDLE and DONE.
- `busy` out 1: high in INIT, SHIFT, CAPTURE, UNLOAD.
- `done` out 1: high in DONE, sticky until the next accepted `start` or reset.
- `pass` out 1: valid when `done`=1; 1 iff signature==`GOLDEN`.
- `signature` out 16: current MISR contents.
- `cut_reset` out 1: active-high synchronous reset to the CUT, high in INIT only.
- `cut_scan_en` out 1: high in SHIFT and UNLOAD.
- `cut_scan_in` out 1: `lfsr[0]` in SHIFT, 0 otherwise.
- `cut_scan_out` in 1: CUT chain output.
- `cut_pi` out PI_W: `lfsr[PI_W-1:0]` in CAPTURE, 0 otherwise.
- `cut_po` in PO_W: CUT primary outputs.

## Operation
- States: IDLE, INIT, SHIFT, CAPTURE, UNLOAD, DONE. State is registered; the `cut_*` drives, `busy` and `done` decode from state.
- IDLE/DONE with `start`=1 → INIT. In INIT: load LFSR←`LFSR_SEED` and MISR←`MISR_SEED`, clear counters, clear `pass`.
- INIT → SHIFT. SHIFT runs for exactly CHAIN_LEN cycles, then goes to CAPTURE.
- CAPTURE lasts 1 cycle and increments the pattern count.
  - If count < NUM_PATTERNS → SHIFT.
  - Else → UNLOAD.
- UNLOAD runs for CHAIN_LEN cycles with scan_in=0, then goes to DONE. On DONE entry, register `pass`.
- `start` is ignored in INIT through UNLOAD. `start` held high in DONE restarts the session; `done` drops on the INIT edge.
- LFSR advances every SHIFT and CAPTURE cycle and holds otherwise.
  - fb = l[0]^l[2]^l[3]^l[5]
  - l_next = {fb, l[15:1]}
- MISR updates in SHIFT, CAPTURE and UNLOAD, and holds otherwise.
  - fb = m[15]^m[13]^m[12]^m[10]
  - m_next = {m[14:0], fb} ^ d
  - In SHIFT/UNLOAD, d = {15'b0, `cut_scan_out`}. In CAPTURE, d = zero-extended `cut_po`.
- The first SHIFT compacts post-reset chain contents. This is deterministic and is included in `GOLDEN`.
- Counters:
  - Bit counter: $clog2(CHAIN_LEN+1) bits, wraps to 0 at each SHIFT/UNLOAD exit.
  - Pattern counter: $clog2(NUM_PATTERNS+1) bits, saturating.

## Timing
- Reset values: state IDLE; `busy`, `done`, `pass`, `cut_reset`, `cut_scan_en`, `cut_scan_in`, `cut_pi` all 0; `signature`=`MISR_SEED`; LFSR=`LFSR_SEED`.
- Counting from the edge that samples `start` as edge 0:
  - INIT occupies edge 0→1.
  - `done` rises after edge 1 + NUM_PATTERNS·(CHAIN_LEN+1) + CHAIN_LEN.
  - With defaults: `busy` lasts 1313 cycles, and `done` is high from edge 1313.
- `cut_scan_out` and `cut_po` are sampled on the same edge that the corresponding state ends. No extra pipeline stage is used.
- `pass` is registered on the UNLOAD→DONE edge and stable throughout DONE.
- Reset asserted mid-session (any state) aborts at once with no partial `done`. A later `start` replays the identical sequence and signature.

## Test plan
- Reset/idle: assert `reset`=0 with random `start` → all outputs at reset values, `signature`=`MISR_SEED`, no state change while reset is low.
- Sequencing: CHAIN_LEN=4, NUM_PATTERNS=2, 4-flop shift-register CUT stub, `start` pulse → `cut_reset` 1 cycle; then `cut_scan_en` pattern 4×1, 1×0, 4×1, 1×0, 4×1; `done`=1 at edge 15.
- LFSR: default seed → first four `cut_scan_in` bits in SHIFT are 1,0,0,0 (LFSR states ACE1, 5670, AB38, 559C).
- Signature: set `GOLDEN` from a bench reference model of the stub → `pass`=1. Force one `cut_po` bit inverted during the 2nd CAPTURE → `pass`=0 and `signature`≠`GOLDEN`.
- Handshake: `start` pulsed mid-SHIFT → ignored, timing unchanged. `start` in DONE → `done` falls next edge, session repeats with identical `signature`.
- Async reset: drop `reset` mid-CAPTURE between edges → outputs clear without a clock edge. The next session's final `signature` equals an uninterrupted run.
